// File: rtl/morse_player_if.sv
// rtl/morse_player_if.sv - request/slot inputs and key/status outputs of the Morse player
interface morse_player_if;
    logic       start;
    logic [1:0] morse_one;
    logic [1:0] morse_two;
    logic [1:0] morse_three;
    logic [1:0] morse_four;
    logic [1:0] morse_five;
    logic       key_out;
    logic       busy;
    logic [2:0] symbol_index;
    logic       done;

    modport master (
        output start, morse_one, morse_two, morse_three, morse_four, morse_five,
        input  key_out, busy, symbol_index, done
    );

    modport slave (
        input  start, morse_one, morse_two, morse_three, morse_four, morse_five,
        output key_out, busy, symbol_index, done
    );
endinterface

// File: rtl/morse_player.sv
// rtl/morse_player.sv - plays one latched five-slot Morse letter as a timed key waveform
module morse_player #(
    parameter int unsigned UNIT_CYCLES      = 50_000_000,
    parameter int unsigned DASH_UNITS       = 3,
    parameter int unsigned LETTER_GAP_UNITS = 3
) (
    input  logic          clock,
    input  logic          reset,
    morse_player_if.slave bus
);
    localparam logic [31:0] DOT_LEN  = 32'(UNIT_CYCLES);
    localparam logic [31:0] DASH_LEN = 32'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [31:0] GAP_LEN  = 32'(LETTER_GAP_UNITS * UNIT_CYCLES);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, LETTER_GAP} state_t;

    state_t      state;
    logic [31:0] counter;
    logic [1:0]  shadow [5];
    logic [2:0]  next_index;
    logic [1:0]  next_sym;
    logic        next_ok;

    function automatic logic sym_valid(input logic [1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    function automatic logic [31:0] mark_load(input logic [1:0] s);
        return (s == 2'b10) ? DASH_LEN - 32'd1 : DOT_LEN - 32'd1;
    endfunction

    // Slot 5 has no successor, so the lookahead reads as an empty symbol there.
    always_comb begin
        next_index = bus.symbol_index + 3'd1;
        next_sym   = 2'b00;
        if (bus.symbol_index < 3'd4)
            next_sym = shadow[next_index];
        next_ok = sym_valid(next_sym);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            counter          <= 32'd0;
            shadow           <= '{default: 2'b00};
            bus.key_out      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.symbol_index <= 3'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.symbol_index <= 3'd0;
                    if (bus.start) begin
                        shadow <= '{bus.morse_one, bus.morse_two, bus.morse_three,
                                    bus.morse_four, bus.morse_five};
                        if (sym_valid(bus.morse_one)) begin
                            state       <= MARK;
                            bus.key_out <= 1'b1;
                            bus.busy    <= 1'b1;
                            counter     <= mark_load(bus.morse_one);
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (counter == 32'd0) begin
                        bus.key_out <= 1'b0;
                        if (next_ok) begin
                            state   <= SPACE;
                            counter <= DOT_LEN - 32'd1;
                        end else begin
                            state   <= LETTER_GAP;
                            counter <= GAP_LEN - 32'd1;
                        end
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                SPACE: begin
                    if (counter == 32'd0) begin
                        state            <= MARK;
                        bus.key_out      <= 1'b1;
                        bus.symbol_index <= next_index;
                        counter          <= mark_load(next_sym);
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                LETTER_GAP: begin
                    if (counter == 32'd0) begin
                        state            <= IDLE;
                        bus.busy         <= 1'b0;
                        bus.done         <= 1'b1;
                        bus.symbol_index <= 3'd0;
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_player.sv
// tb/tb_morse_player.sv - directed self-checking bench for morse_player
module tb_morse_player;
    localparam int UNIT = 4;
    localparam int NC   = 128;

    logic clock = 1'b0;
    logic reset;

    morse_player_if bus ();

    morse_player #(
        .UNIT_CYCLES      (UNIT),
        .DASH_UNITS       (3),
        .LETTER_GAP_UNITS (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic       e_key  [NC];
    logic       e_busy [NC];
    logic       e_done [NC];
    logic [2:0] e_idx  [NC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic vld(input logic [1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    // Timeline of expected outputs: cycle c is the value seen after the c-th edge following start.
    task automatic build(input logic [9:0] sl);
        int c;
        int i;
        int len;
        logic [1:0] s;
        for (int k = 0; k < NC; k++) begin
            e_key[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_idx[k] = 0;
        end
        c = 1;
        s = sl[9:8];
        if (!vld(s)) begin
            e_done[1] = 1;
            return;
        end
        i = 0;
        forever begin
            s   = sl[9-2*i -: 2];
            len = (s == 2'b10) ? 3 * UNIT : UNIT;
            for (int k = 0; k < len; k++) begin
                e_key[c] = 1; e_busy[c] = 1; e_idx[c] = 3'(i); c++;
            end
            if (i < 4 && vld(sl[7-2*i -: 2])) begin
                for (int k = 0; k < UNIT; k++) begin
                    e_busy[c] = 1; e_idx[c] = 3'(i); c++;
                end
                i++;
            end else begin
                break;
            end
        end
        for (int k = 0; k < 3 * UNIT; k++) begin
            e_busy[c] = 1; e_idx[c] = 3'(i); c++;
        end
        e_done[c] = 1;
    endtask

    task automatic set_slots(input logic [9:0] sl);
        bus.morse_one   = sl[9:8];
        bus.morse_two   = sl[7:6];
        bus.morse_three = sl[5:4];
        bus.morse_four  = sl[3:2];
        bus.morse_five  = sl[1:0];
    endtask

    task automatic run(input string name, input logic [9:0] sl, input int ncyc,
                       input int done_at, input int rs_cyc, input int rst_cyc);
        int first_done;
        build(sl);
        if (rst_cyc > 0)
            for (int k = rst_cyc + 1; k < NC; k++) begin
                e_key[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_idx[k] = 0;
            end
        first_done = 0;
        set_slots(sl);
        bus.start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clock);
            #1;
            bus.start = 1'b0;
            reset     = 1'b0;
            check($sformatf("%s key@%0d", name, c), 32'(bus.key_out), 32'(e_key[c]));
            check($sformatf("%s busy@%0d", name, c), 32'(bus.busy), 32'(e_busy[c]));
            check($sformatf("%s done@%0d", name, c), 32'(bus.done), 32'(e_done[c]));
            check($sformatf("%s idx@%0d", name, c), 32'(bus.symbol_index), 32'(e_idx[c]));
            if (bus.done && first_done == 0)
                first_done = c;
            if (c == rs_cyc) begin
                set_slots(10'b10_10_10_10_10);
                bus.start = 1'b1;
            end
            if (c == rst_cyc)
                reset = 1'b1;
        end
        check($sformatf("%s done_cycle", name), 32'(first_done), 32'(done_at));
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        set_slots(10'd0);
        repeat (3) @(posedge clock);
        #1;
        check("reset key", 32'(bus.key_out), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset idx", 32'(bus.symbol_index), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run("A",        10'b01_10_00_00_00, 33, 33, 0, 0);
        run("dots",     10'b01_01_01_01_01, 49, 49, 0, 0);
        run("empty",    10'b00_00_00_00_00,  1,  1, 0, 0);
        run("A_b2b",    10'b01_10_00_00_00, 33, 33, 0, 0);
        run("term00",   10'b01_00_10_10_10, 17, 17, 0, 0);
        run("term11",   10'b01_11_01_01_01, 17, 17, 0, 0);
        run("empty11",  10'b11_01_01_01_01,  1,  1, 0, 0);
        run("A_restart",10'b01_10_00_00_00, 33, 33, 6, 0);
        run("dashes",   10'b10_10_10_10_10, 89, 89, 0, 0);
        run("A_reset",  10'b01_10_00_00_00, 40,  0, 0, 10);
        run("A_after",  10'b01_10_00_00_00, 33, 33, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
